// File: rtl/util_timestamp_gate.sv
// Timestamp gate for the DAC DMA stream: holds early blocks until their target time, drops late ones.
// Optional saturating error counters are built when UTIL_TIMESTAMP_GATE_STATS_EN is defined.
module util_timestamp_gate #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned TIMESTAMP_WIDTH = 64,
  parameter int unsigned EVERY_WIDTH     = 32,
  parameter int unsigned MAX_EARLY       = 1024
) (
  input  logic                       dac_clk,
  input  logic                       reset,
  input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
  input  logic [EVERY_WIDTH-1:0]     timestamp_every,
  input  logic                       s_axis_valid,
  output logic                       s_axis_ready,
  input  logic [DATA_WIDTH-1:0]      s_axis_data,
  input  logic                       s_axis_xfer_req,
  output logic                       m_axis_valid,
  input  logic                       m_axis_ready,
  output logic [DATA_WIDTH-1:0]      m_axis_data,
  output logic                       reset_upack,
  output logic                       late,
`ifdef UTIL_TIMESTAMP_GATE_STATS_EN
  output logic [31:0]                late_count,
  output logic [31:0]                early_count,
`endif
  output logic                       early_err
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWaitTs = 3'd1;
  localparam logic [2:0] StHold   = 3'd2;
  localparam logic [2:0] StStream = 3'd3;
  localparam logic [2:0] StDrop   = 3'd4;

  localparam logic [TIMESTAMP_WIDTH-1:0] MaxEarlyTs = TIMESTAMP_WIDTH'(MAX_EARLY);

  logic [2:0]                 state_q, state_d;
  logic [TIMESTAMP_WIDTH-1:0] ts_tgt_q, ts_tgt_d;
  logic [EVERY_WIDTH-1:0]     every_q, every_d;
  logic [EVERY_WIDTH-1:0]     beat_cnt_q, beat_cnt_d;
  logic                       passthru_q, passthru_d;
  logic                       late_q, late_d;
  logic                       early_q, early_d;
  logic                       upack_q, upack_d;
  logic [TIMESTAMP_WIDTH-1:0] diff;
  logic                       s_hs;
  logic                       last_beat;

  // Modular distance to target; MSB set means the target is already in the past.
  assign diff      = ts_tgt_q - timestamp;
  assign s_hs      = s_axis_valid & s_axis_ready;
  assign last_beat = (beat_cnt_q == every_q - EVERY_WIDTH'(1));

  assign late        = late_q;
  assign early_err   = early_q;
  assign reset_upack = upack_q;

  always_comb begin
    s_axis_ready = 1'b0;
    m_axis_valid = 1'b0;
    m_axis_data  = '0;
    case (state_q)
      StWaitTs, StDrop: s_axis_ready = 1'b1;
      StStream: begin
        s_axis_ready = m_axis_ready;
        m_axis_valid = s_axis_valid;
        m_axis_data  = s_axis_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ts_tgt_d   = ts_tgt_q;
    every_d    = every_q;
    beat_cnt_d = beat_cnt_q;
    passthru_d = passthru_q;
    late_d     = 1'b0;
    early_d    = 1'b0;
    upack_d    = 1'b0;
    // Abort wins over any decision taken in the same cycle.
    if (state_q != StIdle && !s_axis_xfer_req) begin
      state_d = StIdle;
      upack_d = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (s_axis_xfer_req) begin
            every_d    = timestamp_every;
            passthru_d = (timestamp_every == '0);
            state_d    = (timestamp_every == '0) ? StStream : StWaitTs;
          end
        end
        StWaitTs: begin
          if (s_hs) begin
            ts_tgt_d   = s_axis_data[TIMESTAMP_WIDTH-1:0];
            every_d    = timestamp_every;
            beat_cnt_d = '0;
            state_d    = StHold;
          end
        end
        StHold: begin
          if (diff[TIMESTAMP_WIDTH-1]) begin
            late_d  = 1'b1;
            upack_d = 1'b1;
            state_d = StDrop;
          end else if (diff > MaxEarlyTs) begin
            early_d = 1'b1;
            upack_d = 1'b1;
            state_d = StDrop;
          end else if (diff == '0) begin
            state_d = StStream;
          end
        end
        StStream, StDrop: begin
          if (s_hs && !passthru_q) begin
            if (last_beat) state_d = StWaitTs;
            else beat_cnt_d = beat_cnt_q + EVERY_WIDTH'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ts_tgt_q   <= '0;
      every_q    <= '0;
      beat_cnt_q <= '0;
      passthru_q <= 1'b0;
      late_q     <= 1'b0;
      early_q    <= 1'b0;
      upack_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts_tgt_q   <= ts_tgt_d;
      every_q    <= every_d;
      beat_cnt_q <= beat_cnt_d;
      passthru_q <= passthru_d;
      late_q     <= late_d;
      early_q    <= early_d;
      upack_q    <= upack_d;
    end
  end

`ifdef UTIL_TIMESTAMP_GATE_STATS_EN
  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) begin
      late_count  <= '0;
      early_count <= '0;
    end else begin
      if (late_d && late_count != 32'hFFFF_FFFF) late_count <= late_count + 32'd1;
      if (early_d && early_count != 32'hFFFF_FFFF) early_count <= early_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_util_timestamp_gate.sv
// Directed bench for util_timestamp_gate: pass-through, gating, late/early drops, wrap and abort.
module tb_util_timestamp_gate;
  localparam int unsigned DW = 64;
  localparam int unsigned TW = 64;
  localparam int unsigned EW = 32;
  localparam int unsigned ME = 1024;

  logic          dac_clk = 1'b0;
  logic          reset = 1'b1;
  logic [TW-1:0] ts_cnt = '0;
  logic [TW-1:0] ts_base = 64'h0000_0000_0001_0000;
  logic [TW-1:0] timestamp;
  logic [EW-1:0] timestamp_every = '0;
  logic          s_axis_valid = 1'b0;
  logic          s_axis_ready;
  logic [DW-1:0] s_axis_data = '0;
  logic          s_axis_xfer_req = 1'b0;
  logic          m_axis_valid;
  logic          m_axis_ready = 1'b0;
  logic [DW-1:0] m_axis_data;
  logic          reset_upack;
  logic          late;
  logic          early_err;
`ifdef UTIL_TIMESTAMP_GATE_STATS_EN
  logic [31:0]   late_count;
  logic [31:0]   early_count;
`endif

  int n_pass = 0;
  int n_total = 0;

  // Results of the most recent run_block call.
  int rb_hold, rb_fwd, rb_ok, rb_late, rb_early, rb_upack;
  bit rb_ts_seen, rb_open_ok, rb_done;

  always #5 dac_clk = ~dac_clk;
  always @(posedge dac_clk) ts_cnt <= ts_cnt + 1;
  assign timestamp = ts_cnt + ts_base;

  util_timestamp_gate #(
    .DATA_WIDTH     (DW),
    .TIMESTAMP_WIDTH(TW),
    .EVERY_WIDTH    (EW),
    .MAX_EARLY      (ME)
  ) dut (
    .dac_clk        (dac_clk),
    .reset          (reset),
    .timestamp      (timestamp),
    .timestamp_every(timestamp_every),
    .s_axis_valid   (s_axis_valid),
    .s_axis_ready   (s_axis_ready),
    .s_axis_data    (s_axis_data),
    .s_axis_xfer_req(s_axis_xfer_req),
    .m_axis_valid   (m_axis_valid),
    .m_axis_ready   (m_axis_ready),
    .m_axis_data    (m_axis_data),
    .reset_upack    (reset_upack),
    .late           (late),
`ifdef UTIL_TIMESTAMP_GATE_STATS_EN
    .late_count     (late_count),
    .early_count    (early_count),
`endif
    .early_err      (early_err)
  );

  // Drives one timestamp beat (target = timestamp + offset) followed by nbeats data beats
  // tagged {tag, index}, observing the DUT each cycle. Expects the DUT to be in WAIT_TS.
  task automatic run_block(input logic [TW-1:0] offset, input int nbeats, input logic [7:0] tag,
                           input int max_cyc);
    logic [TW-1:0] tgt;
    logic [DW-1:0] exp_data;
    int idx;
    bit opened;
    rb_hold = 0; rb_fwd = 0; rb_ok = 0; rb_late = 0; rb_early = 0; rb_upack = 0;
    rb_ts_seen = 0; rb_open_ok = 0; rb_done = 0;
    idx = 0;
    opened = 0;
    @(negedge dac_clk);
    tgt = timestamp + offset;
    s_axis_valid = 1'b1;
    s_axis_data  = DW'(tgt);
    m_axis_ready = 1'b1;
    #1;
    rb_ts_seen = m_axis_valid;
    for (int c = 0; c < max_cyc && !rb_done; c++) begin
      @(negedge dac_clk);
      exp_data = (DW'(tag) << 8) | DW'(idx);
      s_axis_data = exp_data;
      #1;
      if (late) rb_late++;
      if (early_err) rb_early++;
      if (reset_upack) rb_upack++;
      if (!s_axis_ready && !m_axis_valid) rb_hold++;
      if (m_axis_valid) begin
        if (!opened) begin
          opened = 1;
          rb_open_ok = (timestamp == tgt + 1);
        end
        rb_fwd++;
        if (m_axis_data == exp_data) rb_ok++;
      end
      if (s_axis_ready) begin
        idx++;
        if (idx == nbeats) rb_done = 1;
      end
    end
  endtask

  task automatic idle_beat();
    @(negedge dac_clk);
    s_axis_valid = 1'b0;
  endtask

  task automatic test_reset();
    s_axis_valid = 1'b1;
    s_axis_data = 64'hDEAD_BEEF;
    m_axis_ready = 1'b1;
    s_axis_xfer_req = 1'b1;
    @(negedge dac_clk);
    @(negedge dac_clk);
    #1;
    n_total++;
    if ({s_axis_ready, m_axis_valid, reset_upack, late, early_err} !== 5'b0)
      $display("FAIL reset_flags: rdy/vld/upack/late/early=%b, want 00000",
               {s_axis_ready, m_axis_valid, reset_upack, late, early_err});
    else n_pass++;
    n_total++;
    if (m_axis_data !== '0) $display("FAIL reset_data_gate: got %0h, want 0", m_axis_data);
    else n_pass++;
`ifdef UTIL_TIMESTAMP_GATE_STATS_EN
    n_total++;
    if ({late_count, early_count} !== 64'd0)
      $display("FAIL reset_counters: late=%0d early=%0d, want 0/0", late_count, early_count);
    else n_pass++;
`endif
    s_axis_valid = 1'b0;
    s_axis_data = '0;
    s_axis_xfer_req = 1'b0;
    @(negedge dac_clk);
    reset = 1'b0;
    @(negedge dac_clk);
    #1;
    n_total++;
    if (s_axis_ready !== 1'b0) $display("FAIL idle_ready: got %b, want 0", s_axis_ready);
    else n_pass++;
  endtask

  task automatic test_passthrough();
    int upk;
    upk = 0;
    @(negedge dac_clk);
    timestamp_every = '0;
    s_axis_xfer_req = 1'b1;
    m_axis_ready = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge dac_clk);
      s_axis_valid = 1'b1;
      s_axis_data = DW'(i);
      #1;
      if (reset_upack) upk++;
      n_total++;
      if ({m_axis_valid, s_axis_ready, m_axis_data} !== {1'b1, 1'b1, DW'(i)})
        $display("FAIL passthrough_beat%0d: vld/rdy/data=%b/%b/%0h, want 1/1/%0h",
                 i, m_axis_valid, s_axis_ready, m_axis_data, i);
      else n_pass++;
    end
    n_total++;
    if (upk !== 0) $display("FAIL passthrough_upack: got %0d pulses, want 0", upk);
    else n_pass++;
    @(negedge dac_clk);
    s_axis_valid = 1'b0;
    s_axis_xfer_req = 1'b0;
    @(negedge dac_clk);
    #1;
    n_total++;
    if ({reset_upack, s_axis_ready, m_axis_valid} !== 3'b100)
      $display("FAIL passthrough_abort: upack/rdy/vld=%b, want 100",
               {reset_upack, s_axis_ready, m_axis_valid});
    else n_pass++;
  endtask

  task automatic test_gate_open();
    @(negedge dac_clk);
    timestamp_every = 4;
    s_axis_xfer_req = 1'b1;
    @(negedge dac_clk);
    #1;
    n_total++;
    if ({s_axis_ready, m_axis_valid} !== 2'b10)
      $display("FAIL wait_ts_entry: rdy/vld=%b, want 10", {s_axis_ready, m_axis_valid});
    else n_pass++;
    run_block(1, 4, 8'h01, 64);
    n_total++;
    if (!rb_done || rb_fwd !== 4 || rb_ok !== 4 || rb_ts_seen)
      $display("FAIL gate_open_fwd: done=%0b fwd=%0d ok=%0d ts_seen=%0b, want 1/4/4/0",
               rb_done, rb_fwd, rb_ok, rb_ts_seen);
    else n_pass++;
    n_total++;
    if (!rb_open_ok || rb_hold !== 1)
      $display("FAIL gate_open_time: open_ok=%0b hold=%0d, want 1/1", rb_open_ok, rb_hold);
    else n_pass++;
    n_total++;
    if (rb_late + rb_early + rb_upack !== 0)
      $display("FAIL gate_open_pulses: late=%0d early=%0d upack=%0d, want 0/0/0",
               rb_late, rb_early, rb_upack);
    else n_pass++;
  endtask

  task automatic test_late();
    run_block(-64'sd10, 4, 8'h02, 64);
    n_total++;
    if (rb_late !== 1 || rb_upack !== 1 || rb_early !== 0)
      $display("FAIL late_pulses: late=%0d upack=%0d early=%0d, want 1/1/0",
               rb_late, rb_upack, rb_early);
    else n_pass++;
    n_total++;
    if (!rb_done || rb_fwd !== 0)
      $display("FAIL late_drop: done=%0b fwd=%0d, want 1/0", rb_done, rb_fwd);
    else n_pass++;
`ifdef UTIL_TIMESTAMP_GATE_STATS_EN
    n_total++;
    if (late_count !== 32'd1) $display("FAIL late_count: got %0d, want 1", late_count);
    else n_pass++;
`endif
    run_block(1, 4, 8'h03, 64);
    n_total++;
    if (!rb_done || rb_fwd !== 4 || rb_ok !== 4)
      $display("FAIL after_late_block: done=%0b fwd=%0d ok=%0d, want 1/4/4",
               rb_done, rb_fwd, rb_ok);
    else n_pass++;
  endtask

  task automatic test_hold();
    run_block(5, 4, 8'h04, 64);
    n_total++;
    if (!rb_open_ok || rb_hold < 4)
      $display("FAIL hold_open: open_ok=%0b hold=%0d, want 1/>=4", rb_open_ok, rb_hold);
    else n_pass++;
    n_total++;
    if (rb_fwd !== 4 || rb_ok !== 4 || rb_late + rb_early + rb_upack !== 0)
      $display("FAIL hold_fwd: fwd=%0d ok=%0d err_pulses=%0d, want 4/4/0",
               rb_fwd, rb_ok, rb_late + rb_early + rb_upack);
    else n_pass++;
  endtask

  task automatic test_early();
    run_block(2000, 4, 8'h05, 64);
    n_total++;
    if (rb_early !== 1 || rb_upack !== 1 || rb_late !== 0 || rb_fwd !== 0 || !rb_done)
      $display("FAIL early_drop: early=%0d upack=%0d late=%0d fwd=%0d done=%0b, want 1/1/0/0/1",
               rb_early, rb_upack, rb_late, rb_fwd, rb_done);
    else n_pass++;
    // First HOLD evaluation sees timestamp one past the handshake sample.
    run_block(ME + 1, 4, 8'h06, ME + 64);
    n_total++;
    if (rb_early !== 0 || !rb_open_ok || rb_fwd !== 4)
      $display("FAIL early_edge_ok: early=%0d open_ok=%0b fwd=%0d, want 0/1/4",
               rb_early, rb_open_ok, rb_fwd);
    else n_pass++;
    run_block(ME + 2, 4, 8'h07, 64);
    n_total++;
    if (rb_early !== 1 || rb_fwd !== 0)
      $display("FAIL early_edge_err: early=%0d fwd=%0d, want 1/0", rb_early, rb_fwd);
    else n_pass++;
`ifdef UTIL_TIMESTAMP_GATE_STATS_EN
    n_total++;
    if (early_count !== 32'd2 || late_count !== 32'd1)
      $display("FAIL early_count: early=%0d late=%0d, want 2/1", early_count, late_count);
    else n_pass++;
`endif
  endtask

  task automatic test_wrap();
    @(negedge dac_clk);
    s_axis_valid = 1'b0;
    ts_base = '0 - ts_cnt - 3;
    run_block(6, 4, 8'h08, 64);
    n_total++;
    if (!rb_open_ok || rb_fwd !== 4 || rb_late + rb_early !== 0)
      $display("FAIL wrap_gate: open_ok=%0b fwd=%0d late=%0d early=%0d, want 1/4/0/0",
               rb_open_ok, rb_fwd, rb_late, rb_early);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge dac_clk);
    s_axis_valid = 1'b0;
    timestamp_every = 1;
    for (int b = 0; b < 2; b++) begin
      run_block(1, 1, 8'h10 + 8'(b), 16);
      n_total++;
      if (!rb_done || rb_fwd !== 1 || rb_ok !== 1 || rb_ts_seen)
        $display("FAIL every1_block%0d: done=%0b fwd=%0d ok=%0d ts_seen=%0b, want 1/1/1/0",
                 b, rb_done, rb_fwd, rb_ok, rb_ts_seen);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    int idx;
    idx = 0;
    @(negedge dac_clk);
    s_axis_valid = 1'b0;
    timestamp_every = 4;
    @(negedge dac_clk);
    s_axis_valid = 1'b1;
    s_axis_data = timestamp + 1;
    for (int c = 0; c < 20 && idx < 2; c++) begin
      @(negedge dac_clk);
      s_axis_data = 64'h300 + DW'(idx);
      #1;
      if (m_axis_valid && s_axis_ready) idx++;
    end
    n_total++;
    if (idx !== 2) $display("FAIL abort_prefix: beats=%0d, want 2", idx);
    else n_pass++;
    @(negedge dac_clk);
    s_axis_valid = 1'b0;
    s_axis_xfer_req = 1'b0;
    @(negedge dac_clk);
    #1;
    n_total++;
    if ({reset_upack, s_axis_ready, m_axis_valid, late} !== 4'b1000)
      $display("FAIL abort_pulse: upack/rdy/vld/late=%b, want 1000",
               {reset_upack, s_axis_ready, m_axis_valid, late});
    else n_pass++;
    @(negedge dac_clk);
    #1;
    n_total++;
    if (reset_upack !== 1'b0) $display("FAIL abort_single: upack=%b, want 0", reset_upack);
    else n_pass++;
    @(negedge dac_clk);
    s_axis_xfer_req = 1'b1;
    @(negedge dac_clk);
    #1;
    n_total++;
    if ({s_axis_ready, m_axis_valid} !== 2'b10)
      $display("FAIL abort_rearm: rdy/vld=%b, want 10", {s_axis_ready, m_axis_valid});
    else n_pass++;
    run_block(1, 4, 8'h20, 64);
    n_total++;
    if (!rb_done || rb_fwd !== 4 || rb_ok !== 4 || rb_ts_seen)
      $display("FAIL abort_fresh_block: done=%0b fwd=%0d ok=%0d ts_seen=%0b, want 1/4/4/0",
               rb_done, rb_fwd, rb_ok, rb_ts_seen);
    else n_pass++;
  endtask

  task automatic test_abort_vs_late();
    @(negedge dac_clk);
    s_axis_valid = 1'b1;
    s_axis_data = timestamp - 10;
    @(negedge dac_clk);
    s_axis_valid = 1'b0;
    s_axis_xfer_req = 1'b0;
    @(negedge dac_clk);
    #1;
    n_total++;
    if ({reset_upack, late, early_err, s_axis_ready} !== 4'b1000)
      $display("FAIL abort_vs_late: upack/late/early/rdy=%b, want 1000",
               {reset_upack, late, early_err, s_axis_ready});
    else n_pass++;
`ifdef UTIL_TIMESTAMP_GATE_STATS_EN
    n_total++;
    if (late_count !== 32'd1) $display("FAIL abort_vs_late_count: got %0d, want 1", late_count);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_gate_open();
    test_late();
    test_hold();
    test_early();
    test_wrap();
    test_back_to_back();
    test_abort();
    test_abort_vs_late();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
